// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial add engine.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// Single-bit full adder cell driven by the serial add controller.
module Full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add engine: one full-adder cell, LSB first, WIDTH cycles per operation.
// Optional subtract mode is compiled in with `define SERIAL_ADD_SUB_EN.
module serial_adder_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out
);

  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_res_sr;
  logic [WIDTH-1:0] r_sum;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_busy;
  logic             r_done;
  logic             r_cout;

  logic             w_fa_b;
  logic             w_fa_sum;
  logic             w_fa_cout;
  logic             w_carry_init;

`ifdef SERIAL_ADD_SUB_EN
  logic r_sub;

  // Two's complement subtract: invert B per bit and inject the +1 through the carry.
  assign w_fa_b       = r_b_sr[0] ^ r_sub;
  assign w_carry_init = sub;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sub <= 1'b0;
    end else if (r_state == ST_IDLE && start) begin
      r_sub <= sub;
    end
  end
`else
  logic w_unused_sub;

  assign w_unused_sub = sub;
  assign w_fa_b       = r_b_sr[0];
  assign w_carry_init = 1'b0;
`endif

  Full_adder u_fa (
    .i_a    (r_a_sr[0]),
    .i_b    (w_fa_b),
    .i_cin  (r_carry),
    .o_sum  (w_fa_sum),
    .o_cout (w_fa_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_res_sr <= '0;
      r_sum    <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_cout   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a_sr  <= a_in;
            r_b_sr  <= b_in;
            r_carry <= w_carry_init;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_a_sr   <= r_a_sr >> 1;
          r_b_sr   <= r_b_sr >> 1;
          r_res_sr <= {w_fa_sum, r_res_sr[WIDTH-1:1]};
          r_carry  <= w_fa_cout;
          r_cnt    <= r_cnt + CNT_W'(1);
          // Last bit: publish the fully assembled word in the same edge as the shift.
          if (r_cnt == LAST_CNT) begin
            r_sum   <= {w_fa_sum, r_res_sr[WIDTH-1:1]};
            r_cout  <= w_fa_cout;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign sum_out  = r_sum;
  assign cout_out = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: expected results queued at issue, checked on done.
module tb_serial_adder_ctrl;

  localparam int W = 32;
`ifdef SERIAL_ADD_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] sum_out;
  logic         cout_out;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a_in     (a_in),
    .b_in     (b_in),
    .sub      (sub),
    .busy     (busy),
    .done     (done),
    .sum_out  (sum_out),
    .cout_out (cout_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    int           due;
    string        tag;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic s);
    logic [W:0] r;
    if (SUB_EN && s) r = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    else             r = {1'b0, a} + {1'b0, b};
    return r;
  endfunction

  // Output monitor: compares every done pulse against the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (done) begin
        if (sb.size() == 0) begin
          check("spurious_done", 64'(done), 64'd0);
        end else begin
          e = sb.pop_front();
          check({e.tag, "_latency"}, 64'(cyc), 64'(e.due));
          check({e.tag, "_sum"}, 64'(sum_out), 64'(e.sum));
          check({e.tag, "_cout"}, 64'(cout_out), 64'(e.cout));
          $display("op %s: sum=0x%08h cout=%0d at cycle %0d", e.tag, sum_out, cout_out, cyc);
        end
      end else if (sb.size() != 0 && cyc > sb[0].due) begin
        e = sb.pop_front();
        check({e.tag, "_done_missing"}, 64'(done), 64'd1);
      end
    end
  end

  task automatic issue(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s, input bit expect_done);
    exp_t       e;
    logic [W:0] r;
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    sub   = s;
    start = 1'b1;
    if (expect_done) begin
      r     = model(a, b, s);
      e.sum = r[W-1:0];
      e.cout = r[W];
      e.due = cyc + 1 + W;
      e.tag = tag;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 4 * W && sb.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    check({tag, "_drain_timeout"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    exp_t       e;
    logic [W:0] r;
    int         d;

    rst_n = 1'b0;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    sub   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_sum", 64'(sum_out), 64'd0);
    check("rst_cout", 64'(cout_out), 64'd0);
    rst_n = 1'b1;

    // 1: basic add, busy held for exactly W cycles
    issue("t1_5p3", 32'h0000_0005, 32'h0000_0003, 1'b0, 1'b1);
    for (int i = 0; i < W; i++) begin
      check("t1_busy", 64'(busy), 64'd1);
      @(negedge clk);
    end
    check("t1_busy_end", 64'(busy), 64'd0);
    drain("t1");

    // 2: carry out of the MSB
    issue("t2_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
    drain("t2");

    // 3: start while busy must be ignored
    issue("t3_run", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    issue("t3_ignored", 32'h0, 32'h0, 1'b0, 1'b0);
    drain("t3");

    // 4: start held through the done cycle -> back-to-back accept
    @(negedge clk);
    a_in  = 32'h8000_0000;
    b_in  = 32'h8000_0000;
    sub   = 1'b0;
    start = 1'b1;
    r      = model(a_in, b_in, 1'b0);
    e.sum  = r[W-1:0];
    e.cout = r[W];
    e.due  = cyc + 1 + W;
    e.tag  = "t4_first";
    sb.push_back(e);
    d = e.due;
    while (cyc < d) @(negedge clk);
    e.due = cyc + 1 + W;
    e.tag = "t4_second";
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    drain("t4");

    // 5: asynchronous reset mid-operation discards the op
    issue("t5_aborted", 32'h0000_1234, 32'h0000_0001, 1'b0, 1'b0);
    repeat (15) @(negedge clk);
    check("t5_busy_pre", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_busy", 64'(busy), 64'd0);
    check("t5_async_done", 64'(done), 64'd0);
    check("t5_async_sum", 64'(sum_out), 64'd0);
    check("t5_async_cout", 64'(cout_out), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue("t5_7p9", 32'h0000_0007, 32'h0000_0009, 1'b0, 1'b1);
    drain("t5");
    repeat (W + 4) @(negedge clk);

    // 6: subtract requests (honoured only when the feature is built in)
    issue("t6_5m3", 32'h0000_0005, 32'h0000_0003, 1'b1, 1'b1);
    drain("t6a");
    issue("t6_3m5", 32'h0000_0003, 32'h0000_0005, 1'b1, 1'b1);
    drain("t6b");

    // Random operands and modes
    for (int i = 0; i < 8; i++) begin
      issue($sformatf("rnd%0d", i), W'($urandom), W'($urandom), 1'($urandom_range(1)), 1'b1);
      drain($sformatf("rnd%0d", i));
    end

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
